// File: rtl/sar_result_averager_pkg.sv
// sar_avg_pkg: shared FSM state type and default parameters for the SAR result averager
package sar_avg_pkg;
  localparam int N_BITS_DEF = 10;
  localparam int LOG2_AVG_DEF = 2;
  localparam int TIMEOUT_CYCLES_DEF = 64;
  typedef enum logic [2:0] {IDLE, HOLD, CAPTURE, RELEASE, DONE} sar_state_e;
endpackage

// File: rtl/sar_result_averager_if.sv
// sar_result_averager_if: control, ADC and result-stream signals of the averager
interface sar_result_averager_if import sar_avg_pkg::*; #(parameter int N_BITS = N_BITS_DEF);
  logic start;
  logic busy;
  logic hold_digital;
  logic adc_eoc;
  logic [N_BITS-1:0] adc_result;
  logic [N_BITS-1:0] avg_result;
  logic avg_valid;
  logic avg_ready;
  logic timeout_err;
  modport master (
    output start, adc_eoc, adc_result, avg_ready,
    input  busy, hold_digital, avg_result, avg_valid, timeout_err
  );
  modport slave (
    input  start, adc_eoc, adc_result, avg_ready,
    output busy, hold_digital, avg_result, avg_valid, timeout_err
  );
endinterface

// File: rtl/sar_result_averager_edge_detect.sv
// sar_edge_detect: registered previous value and rising-edge flag of a 1-bit input
module sar_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic rise_o
);
  logic prev_q;
  // previous-cycle value of the input
  always_ff @(posedge clk) prev_q <= reset ? 1'b0 : d_i;
  assign rise_o = d_i & ~prev_q;
endmodule

// File: rtl/sar_result_averager.sv
// sar_result_averager: sequences 2^LOG2_AVG ADC conversions and outputs their rounded mean
module sar_result_averager import sar_avg_pkg::*; #(
  parameter int N_BITS = N_BITS_DEF,
  parameter int LOG2_AVG = LOG2_AVG_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input logic clk,
  input logic reset,
  sar_result_averager_if.slave bus
);
  localparam int ACC_W = N_BITS + LOG2_AVG + 1;
  localparam int CW = LOG2_AVG + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] NS = CW'(1) << LOG2_AVG;
  localparam logic [ACC_W-1:0] HALF = (LOG2_AVG == 0) ? '0 : ACC_W'(1) << (LOG2_AVG > 0 ? LOG2_AVG - 1 : 0);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  sar_state_e state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [N_BITS-1:0] smp_q, smp_d;
  logic [N_BITS-1:0] avg_q, avg_d;
  logic to_q, to_d;
  logic eoc_rise;
  sar_edge_detect u_edge (
    .clk   (clk),
    .reset (reset),
    .d_i   (bus.adc_eoc),
    .rise_o(eoc_rise)
  );
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q <= '0;
      cnt_q <= '0;
      tcnt_q <= '0;
      smp_q <= '0;
      avg_q <= '0;
      to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      tcnt_q <= tcnt_d;
      smp_q <= smp_d;
      avg_q <= avg_d;
      to_q <= to_d;
    end
  end
  // next state; the timeout counter runs only in HOLD and restarts on every HOLD entry
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    tcnt_d = '0;
    smp_d = smp_q;
    avg_d = avg_q;
    to_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d = '0;
          cnt_d = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        tcnt_d = tcnt_q + 1'b1;
        if (eoc_rise) begin
          smp_d = bus.adc_result;
          state_d = CAPTURE;
        end else if (tcnt_q == T_LAST) begin
          to_d = 1'b1;
          acc_d = '0;
          cnt_d = '0;
          state_d = IDLE;
        end
      end
      CAPTURE: begin
        acc_d = acc_q + ACC_W'(smp_q);
        cnt_d = cnt_q + 1'b1;
        state_d = RELEASE;
      end
      RELEASE: begin
        if (!bus.adc_eoc) begin
          state_d = (cnt_q < NS) ? HOLD : DONE;
          avg_d = (cnt_q < NS) ? avg_q : N_BITS'((acc_q + HALF) >> LOG2_AVG);
        end
      end
      DONE: state_d = bus.avg_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  assign bus.busy = state_q != IDLE;
  assign bus.hold_digital = state_q == HOLD;
  assign bus.avg_valid = state_q == DONE;
  assign bus.avg_result = avg_q;
  assign bus.timeout_err = to_q;
endmodule

// File: tb/tb_sar_result_averager.sv
// tb_sar_result_averager: randomized self-checking bench against a rounded-mean reference model
module tb_sar_result_averager;
  localparam int NS = 4;
  logic clk = 1'b0;
  logic reset;
  int n_chk = 0;
  int n_fail = 0;
  int hold_cnt = 0;
  int to_cnt = 0;
  int valid_cnt = 0;
  logic hold_prev = 1'b0;
  logic valid_prev = 1'b0;
  sar_result_averager_if #(.N_BITS(10)) bus ();
  sar_result_averager #(.N_BITS(10), .LOG2_AVG(2), .TIMEOUT_CYCLES(64)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.hold_digital && !hold_prev) hold_cnt <= hold_cnt + 1;
    if (bus.avg_valid && !valid_prev) valid_cnt <= valid_cnt + 1;
    if (bus.timeout_err) to_cnt <= to_cnt + 1;
    hold_prev <= bus.hold_digital;
    valid_prev <= bus.avg_valid;
  end
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int ref_avg(input int s[NS]);
    int sum = 0;
    foreach (s[i]) sum += s[i];
    return (sum + NS / 2) / NS;
  endfunction
  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic convert(input int val, input int dly);
    int n = 0;
    while (!bus.hold_digital && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.hold_digital) begin
      check("hold_wait", 0, 1);
      return;
    end
    repeat (dly) @(negedge clk);
    bus.adc_result = 10'(val);
    bus.adc_eoc = 1'b1;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    bus.adc_eoc = 1'b0;
    bus.adc_result = 10'($urandom);
  endtask
  task automatic wait_valid();
    int n = 0;
    while (!bus.avg_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("valid_wait", int'(bus.avg_valid), 1);
  endtask
  task automatic accept();
    bus.avg_ready = 1'b1;
    @(negedge clk);
    bus.avg_ready = 1'b0;
    check("idle_after_accept", int'(bus.busy), 0);
    check("valid_after_accept", int'(bus.avg_valid), 0);
  endtask
  task automatic run_avg(input int s[NS], input int d[NS], input string tag);
    int h0 = hold_cnt;
    int t0 = to_cnt;
    pulse_start();
    for (int i = 0; i < NS; i++) convert(s[i], d[i]);
    wait_valid();
    check({tag, "_avg"}, int'(bus.avg_result), ref_avg(s));
    check({tag, "_pulses"}, hold_cnt - h0, NS);
    check({tag, "_no_timeout"}, to_cnt - t0, 0);
    accept();
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int s[NS];
    int d[NS];
    int n;
    int r;
    int v0;
    int t0;
    logic stable;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.adc_eoc = 1'b0;
    bus.adc_result = '0;
    bus.avg_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_hold", int'(bus.hold_digital), 0);
    check("rst_valid", int'(bus.avg_valid), 0);
    check("rst_timeout", int'(bus.timeout_err), 0);
    check("rst_result", int'(bus.avg_result), 0);
    reset = 1'b0;
    @(negedge clk);
    run_avg('{100, 101, 102, 103}, '{2, 5, 0, 9}, "seq100");
    check("seq100_exact", int'(bus.avg_result), 102);
    run_avg('{1023, 1023, 1023, 1023}, '{1, 1, 1, 1}, "full_scale");
    check("full_scale_exact", int'(bus.avg_result), 1023);
    run_avg('{7, 300, 999, 2}, '{63, 0, 63, 4}, "late_eoc");
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NS; i++) begin
        s[i] = int'($urandom_range(0, 1023));
        d[i] = ($urandom_range(0, 7) == 0) ? 63 : int'($urandom_range(0, 12));
      end
      run_avg(s, d, "rand");
    end
    v0 = valid_cnt;
    t0 = to_cnt;
    pulse_start();
    n = 0;
    while (!bus.timeout_err && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycle", n, 64);
    check("timeout_idle", int'(bus.busy), 0);
    @(negedge clk);
    check("timeout_one_pulse", int'(bus.timeout_err), 0);
    check("timeout_count", to_cnt - t0, 1);
    check("timeout_no_valid", valid_cnt - v0, 0);
    for (int i = 0; i < NS; i++) s[i] = int'($urandom_range(0, 1023));
    pulse_start();
    for (int i = 0; i < NS; i++) convert(s[i], int'($urandom_range(0, 6)));
    wait_valid();
    r = int'(bus.avg_result);
    check("bp_avg", r, ref_avg(s));
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      bus.start = (c % 3 == 0);
      bus.adc_eoc = (c >= 3 && c < 6);
      @(negedge clk);
      if (int'(bus.avg_result) != r || !bus.avg_valid) stable = 1'b0;
    end
    bus.start = 1'b0;
    bus.adc_eoc = 1'b0;
    @(negedge clk);
    check("bp_stable", int'(stable), 1);
    accept();
    repeat (3) @(negedge clk);
    check("bp_start_not_queued", int'(bus.busy), 0);
    v0 = valid_cnt;
    t0 = to_cnt;
    pulse_start();
    convert(500, 3);
    convert(900, 1);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_hold", int'(bus.hold_digital), 0);
    check("abort_valid", int'(bus.avg_valid), 0);
    reset = 1'b0;
    @(negedge clk);
    check("abort_no_valid", valid_cnt - v0, 0);
    check("abort_no_timeout", to_cnt - t0, 0);
    run_avg('{8, 8, 8, 8}, '{0, 3, 6, 1}, "after_abort");
    check("after_abort_exact", int'(bus.avg_result), 8);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
